simon_enc_ctrl: RTL

Iterative Simon128/128 encryption engine with a valid/ready front end. It accepts one 128-bit plaintext and one 128-bit key, expands round keys on the fly, and applies one Simon round per clock for ROUNDS cycles. It then presents the ciphertext until the consumer takes it. It sits between the bus/host interface and the cipher datapath, and is the only block that sequences rounds and key expansion.

---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_enc_ctrl_if.sv | 24 ++
 rtl/simon_key_sched.sv | 34 +++
 rtl/simon_enc_ctrl.sv | 83 ++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types, constants and rotate helpers for the Simon128/128 engine.
package simon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int          SIMON_ROUNDS = 68;
  localparam logic [63:0] SIMON_C      = 64'hFFFF_FFFF_FFFF_FFFC;
  // z2[0] is the leftmost character, so it lives in the MSB.
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

  function automatic logic [63:0] rol64(input logic [63:0] v, input int unsigned n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic z2_bit(input logic [6:0] r);
    logic [6:0] idx7;
    logic [5:0] idx;
    idx7 = (r < 7'd62) ? r : r - 7'd62;
    idx  = idx7[5:0];
    return Z2[6'd61 - idx];
  endfunction

endpackage

// File: rtl/simon_enc_ctrl_if.sv
// Request/response bundle for simon_enc_ctrl; abort_i exists only with SIMON_ABORT_EN.
interface simon_enc_ctrl_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] pt_i;
  logic [127:0] key_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] ct_o;
  logic         busy_o;
`ifdef SIMON_ABORT_EN
  logic         abort_i;

  modport master (output in_valid_i, pt_i, key_i, out_ready_i, abort_i,
                  input  in_ready_o, out_valid_o, ct_o, busy_o);
  modport slave  (input  in_valid_i, pt_i, key_i, out_ready_i, abort_i,
                  output in_ready_o, out_valid_o, ct_o, busy_o);
`else
  modport master (output in_valid_i, pt_i, key_i, out_ready_i,
                  input  in_ready_o, out_valid_o, ct_o, busy_o);
  modport slave  (input  in_valid_i, pt_i, key_i, out_ready_i,
                  output in_ready_o, out_valid_o, ct_o, busy_o);
`endif
endinterface

// File: rtl/simon_key_sched.sv
// On-the-fly Simon128/128 key expansion: a two-word window (ka, kb), kr = ka.
module simon_key_sched
  import simon_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [6:0]   round_idx,
  input  logic [127:0] key,
  output logic [63:0]  kr
);

  logic [63:0] ka_reg, kb_reg;
  logic [63:0] t, knew;

  assign t    = ror64(kb_reg, 3);
  assign knew = SIMON_C ^ {63'd0, z2_bit(round_idx)} ^ ka_reg ^ t ^ ror64(t, 1);
  assign kr   = ka_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ka_reg <= '0;
      kb_reg <= '0;
    end else if (load) begin
      ka_reg <= key[63:0];
      kb_reg <= key[127:64];
    end else if (step) begin
      ka_reg <= kb_reg;
      kb_reg <= knew;
    end
  end

endmodule

// File: rtl/simon_enc_ctrl.sv
// Iterative Simon128/128 encryptor, one round per clock, valid/ready on both sides.
// Define SIMON_ABORT_EN to add abort_i, which returns RUN/DONE to IDLE and clears the result.
module simon_enc_ctrl
  import simon_pkg::*;
#(
  parameter int ROUNDS = SIMON_ROUNDS
)
(
  input  logic              clk,
  input  logic              rst_n,
  simon_enc_ctrl_if.slave   bus
);

  state_t       state_reg;
  logic [63:0]  x_reg, y_reg;
  logic [6:0]   r_reg;
  logic [127:0] ct_reg;
  logic [63:0]  kr, x_next;
  logic         accept, last_round, abort_req;

`ifdef SIMON_ABORT_EN
  assign abort_req = bus.abort_i && (state_reg != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign accept     = (state_reg == IDLE) && bus.in_valid_i;
  assign last_round = (r_reg == 7'(ROUNDS - 1));
  assign x_next     = y_reg ^ (rol64(x_reg, 1) & rol64(x_reg, 8)) ^ rol64(x_reg, 2) ^ kr;

  simon_key_sched u_key_sched (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (state_reg == RUN),
    .round_idx (r_reg),
    .key       (bus.key_i),
    .kr        (kr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      r_reg     <= '0;
      ct_reg    <= '0;
    end else if (abort_req) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      r_reg     <= '0;
      ct_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.in_valid_i) begin
          x_reg     <= bus.pt_i[127:64];
          y_reg     <= bus.pt_i[63:0];
          r_reg     <= '0;
          state_reg <= RUN;
        end
        RUN: begin
          x_reg <= x_next;
          y_reg <= x_reg;
          r_reg <= r_reg + 7'd1;
          // Capture the result on the final round so ct_o is a plain register in DONE.
          if (last_round) begin
            ct_reg    <= {x_next, x_reg};
            state_reg <= DONE;
          end
        end
        DONE: if (bus.out_ready_i) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (state_reg == IDLE);
  assign bus.out_valid_o = (state_reg == DONE);
  assign bus.busy_o      = (state_reg == RUN);
  assign bus.ct_o        = ct_reg;

endmodule
